// File: rtl/my_counter_pkg.sv
// Shared definitions for the multi-channel AXI-Lite counter: register map,
// control/status bit positions, handshake states and a byte-strobe merge helper.
package my_counter_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_SAT    = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

  // Field order puts en at bit 0, matching the CTRL register layout.
  typedef struct packed {
    logic irq_en;
    logic sat;
    logic dir;
    logic en;
  } ctrl_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/my_counter_channel.sv
// One counter channel: CTRL/COUNT/CMP/STATUS registers, the counting datapath
// and the per-channel interrupt request.
module my_counter_channel
  import my_counter_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 ctrl_we,
  input  logic                 count_we,
  input  logic                 cmp_we,
  input  logic                 status_we,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  output logic [31:0]          ctrl_rd,
  output logic [31:0]          count_rd,
  output logic [31:0]          cmp_rd,
  output logic [31:0]          status_rd,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 irq_req
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  ctrl_t                ctrl_reg;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic [CNT_WIDTH-1:0] cmp_reg;
  logic [1:0]           status_reg, status_next;
  logic [31:0]          count_wr, cmp_wr;
  logic                 ovf_set, match_set;

  assign count_wr = apply_strobe(32'(count_reg), wdata, wstrb);
  assign cmp_wr   = apply_strobe(32'(cmp_reg), wdata, wstrb);

  // A load takes priority over counting; the loaded value still feeds the match test.
  always_comb begin
    count_next = count_reg;
    ovf_set    = 1'b0;
    if (count_we) begin
      count_next = count_wr[CNT_WIDTH-1:0];
    end else if (ctrl_reg.en) begin
      if (!ctrl_reg.dir) begin
        if (count_reg == CNT_MAX) begin
          ovf_set    = 1'b1;
          count_next = ctrl_reg.sat ? count_reg : '0;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end else begin
        if (count_reg == '0) begin
          ovf_set    = 1'b1;
          count_next = ctrl_reg.sat ? count_reg : CNT_MAX;
        end else begin
          count_next = count_reg - CNT_ONE;
        end
      end
    end
    match_set = ctrl_reg.en && (count_next == cmp_reg);
  end

  // Hardware sets are OR-ed in after the W1C clear so they win a same-cycle collision.
  always_comb begin
    status_next = status_reg;
    if (status_we && wstrb[0]) status_next = status_next & ~wdata[1:0];
    status_next[STAT_MATCH] = status_next[STAT_MATCH] | match_set;
    status_next[STAT_OVF]   = status_next[STAT_OVF]   | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ctrl_reg   <= '0;
      count_reg  <= '0;
      cmp_reg    <= '0;
      status_reg <= '0;
    end else begin
      if (ctrl_we && wstrb[0]) ctrl_reg <= ctrl_t'(wdata[3:0]);
      if (cmp_we) cmp_reg <= cmp_wr[CNT_WIDTH-1:0];
      count_reg  <= count_next;
      status_reg <= status_next;
    end
  end

  assign ctrl_rd   = {28'd0, ctrl_reg};
  assign count_rd  = 32'(count_reg);
  assign cmp_rd    = 32'(cmp_reg);
  assign status_rd = {30'd0, status_reg};
  assign count     = count_reg;
  assign irq_req   = ctrl_reg.irq_en & (|status_reg);

  logic unused_ok;
  assign unused_ok = ^{count_wr, cmp_wr, wdata, ctrl_reg.sat};

endmodule

// File: rtl/my_counter_axi_multi.sv
// AXI4-Lite front end for NUM_CH counter channels: write/read handshake FSMs,
// register decode, read mux and the registered interrupt output.
module my_counter_axi_multi
  import my_counter_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int CNT_WIDTH          = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = $clog2(NUM_CH) + 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          irq,
  output logic [NUM_CH*CNT_WIDTH-1:0]   count_o
);

  wr_state_t   wr_state_reg;
  rd_state_t   rd_state_reg;
  logic        awready_reg, wready_reg, bvalid_reg;
  logic        arready_reg, rvalid_reg;
  logic [31:0] rdata_reg, rd_mux;
  logic        irq_reg;
  logic        wr_fire, rd_fire;

  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_ch, rd_ch;
  logic [1:0]                    wr_reg, rd_reg;
  logic [NUM_CH-1:0]             irq_req;
  logic [31:0]                   reg_rd [NUM_CH][4];

  assign wr_ch  = S_AXI_AWADDR >> 4;
  assign rd_ch  = S_AXI_ARADDR >> 4;
  assign wr_reg = S_AXI_AWADDR[3:2];
  assign rd_reg = S_AXI_ARADDR[3:2];

  // Handshake completes on the edge where the registered READY pulse meets VALID.
  assign wr_fire = awready_reg && wready_reg && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire = arready_reg && S_AXI_ARVALID;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic sel;
      assign sel = wr_fire && (wr_ch == C_S_AXI_ADDR_WIDTH'(gi));

      my_counter_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
        .clk       (S_AXI_ACLK),
        .srst      (S_AXI_ARESET),
        .ctrl_we   (sel && (wr_reg == REG_CTRL)),
        .count_we  (sel && (wr_reg == REG_COUNT)),
        .cmp_we    (sel && (wr_reg == REG_CMP)),
        .status_we (sel && (wr_reg == REG_STATUS)),
        .wdata     (S_AXI_WDATA),
        .wstrb     (S_AXI_WSTRB),
        .ctrl_rd   (reg_rd[gi][REG_CTRL]),
        .count_rd  (reg_rd[gi][REG_COUNT]),
        .cmp_rd    (reg_rd[gi][REG_CMP]),
        .status_rd (reg_rd[gi][REG_STATUS]),
        .count     (count_o[gi*CNT_WIDTH +: CNT_WIDTH]),
        .irq_req   (irq_req[gi])
      );
    end
  endgenerate

  // Out-of-range channels fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(rd_ch) == i) rd_mux = reg_rd[i][rd_reg];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_state_reg <= W_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          if (wr_fire) begin
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b1;
            wr_state_reg <= W_RESP;
          end else begin
            awready_reg <= S_AXI_AWVALID && S_AXI_WVALID;
            wready_reg  <= S_AXI_AWVALID && S_AXI_WVALID;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_reg   <= 1'b0;
            wr_state_reg <= W_IDLE;
          end
        end
        default: wr_state_reg <= W_IDLE;
      endcase
    end
  end

  // RDATA is captured at the address handshake, so a same-edge write is not yet visible.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (rd_fire) begin
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b1;
            rdata_reg    <= rd_mux;
            rd_state_reg <= R_DATA;
          end else begin
            arready_reg <= S_AXI_ARVALID;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_reg   <= 1'b0;
            rd_state_reg <= R_IDLE;
          end
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) irq_reg <= 1'b0;
    else              irq_reg <= |irq_req;
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_reg;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_my_counter_axi_multi.sv
// Directed bench for my_counter_axi_multi with three channels so that channel
// index NUM_CH is addressable.
module tb_my_counter_axi_multi;

  localparam int NUM_CH = 3;
  localparam int CW     = 32;
  localparam int AW     = $clog2(NUM_CH) + 4;

  logic              clk = 1'b0;
  logic              srst;
  logic [AW-1:0]     S_AXI_AWADDR = '0;
  logic              S_AXI_AWVALID = 1'b0;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA = '0;
  logic [3:0]        S_AXI_WSTRB = '0;
  logic              S_AXI_WVALID = 1'b0;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY = 1'b0;
  logic [AW-1:0]     S_AXI_ARADDR = '0;
  logic              S_AXI_ARVALID = 1'b0;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY = 1'b0;
  logic              irq;
  logic [NUM_CH*CW-1:0] count_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic [1:0]  rr;

  always #5 clk = ~clk;

  my_counter_axi_multi #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(srst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .irq(irq), .count_o(count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return count_o[ch*CW +: CW];
  endfunction

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin tick(1); n++; end
    chk("wr_ready", 32'(n < 20), 32'd1);
    tick(1);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("bvalid", 32'(S_AXI_BVALID), 32'd1);
    chk("bresp", 32'(S_AXI_BRESP), 32'd0);
    S_AXI_BREADY = 1'b1;
    tick(1);
    S_AXI_BREADY = 1'b0;
    $display("WR addr=%h data=%h strb=%h", addr, data, strb);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin tick(1); n++; end
    chk("rd_ready", 32'(n < 20), 32'd1);
    tick(1);
    S_AXI_ARVALID = 1'b0;
    chk("rvalid", 32'(S_AXI_RVALID), 32'd1);
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    tick(1);
    S_AXI_RREADY = 1'b0;
    $display("RD addr=%h data=%h resp=%h", addr, data, resp);
  endtask

  initial begin
    // 1: reset state
    srst = 1'b1;
    tick(3);
    srst = 1'b0;
    tick(1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < 4; r++) begin
        axi_read(AW'(c*16 + r*4), rd, rr);
        chk("rst_reg", rd, 32'd0);
        chk("rst_rresp", 32'(rr), 32'd0);
      end
    end

    // 2: ch0 compare match and irq
    axi_write(6'h08, 32'd5, 4'hF);
    axi_write(6'h00, 32'h9, 4'hF);
    chk("t2_cnt1", cnt(0), 32'd1);
    tick(4);
    chk("t2_cnt5", cnt(0), 32'd5);
    chk("t2_irq_pre", 32'(irq), 32'd0);
    tick(1);
    chk("t2_irq", 32'(irq), 32'd1);
    axi_read(6'h0C, rd, rr);
    chk("t2_status", rd, 32'h1);
    axi_write(6'h0C, 32'h1, 4'hF);
    chk("t2_irq_clr", 32'(irq), 32'd0);
    axi_read(6'h0C, rd, rr);
    chk("t2_status_clr", rd, 32'h0);

    // 3: ch1 wrap then saturate
    axi_write(6'h14, 32'hFFFF_FFFE, 4'hF);
    axi_write(6'h10, 32'h1, 4'hF);
    chk("t3_max", cnt(1), 32'hFFFF_FFFF);
    tick(1);
    chk("t3_wrap", cnt(1), 32'h0);
    axi_read(6'h1C, rd, rr);
    chk("t3_status", rd, 32'h3);
    axi_write(6'h10, 32'h0, 4'hF);
    axi_write(6'h1C, 32'h3, 4'hF);
    axi_write(6'h14, 32'hFFFF_FFFE, 4'hF);
    axi_write(6'h10, 32'h5, 4'hF);
    chk("t3_sat_max", cnt(1), 32'hFFFF_FFFF);
    tick(3);
    chk("t3_sat_hold", cnt(1), 32'hFFFF_FFFF);
    axi_read(6'h1C, rd, rr);
    chk("t3_sat_status", rd, 32'h2);
    axi_write(6'h10, 32'h0, 4'hF);

    // 4: ch2 down-count wrap then saturate
    axi_write(6'h24, 32'd2, 4'hF);
    axi_write(6'h20, 32'h3, 4'hF);
    chk("t4_dn1", cnt(2), 32'd1);
    tick(1);
    chk("t4_dn0", cnt(2), 32'd0);
    tick(1);
    chk("t4_dnwrap", cnt(2), 32'hFFFF_FFFF);
    axi_write(6'h20, 32'h0, 4'hF);
    axi_write(6'h24, 32'd2, 4'hF);
    axi_write(6'h20, 32'h7, 4'hF);
    chk("t4_sat1", cnt(2), 32'd1);
    tick(1);
    chk("t4_sat0", cnt(2), 32'd0);
    tick(2);
    chk("t4_sat_hold", cnt(2), 32'd0);
    axi_write(6'h20, 32'h0, 4'hF);
    axi_read(6'h2C, rd, rr);
    chk("t4_status", rd, 32'h3);

    // 5: load beats increment on running ch0; load to CMP value raises match
    axi_write(6'h04, 32'h10, 4'hF);
    chk("t5_load", cnt(0), 32'h11);
    tick(1);
    chk("t5_load_inc", cnt(0), 32'h12);
    axi_write(6'h04, 32'd5, 4'hF);
    chk("t5_load_irq", 32'(irq), 32'd1);
    chk("t5_load_cnt", cnt(0), 32'd6);
    axi_write(6'h00, 32'h0, 4'hF);
    axi_write(6'h0C, 32'h1, 4'hF);
    chk("t5_irq_off", 32'(irq), 32'd0);

    // 5b: AW leads W by three cycles, BVALID held until BREADY
    S_AXI_AWADDR = 6'h18; S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t5_aw_wait", 32'(S_AXI_AWREADY), 32'd0);
    end
    S_AXI_WDATA = 32'h1234_ABCD; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    begin
      int n = 0;
      while (!S_AXI_AWREADY && n < 20) begin tick(1); n++; end
      chk("t5_aw_ready", 32'(n < 20), 32'd1);
    end
    tick(1);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_bhold", 32'(S_AXI_BVALID), 32'd1);
      tick(1);
    end
    S_AXI_BREADY = 1'b1;
    tick(1);
    S_AXI_BREADY = 1'b0;
    chk("t5_bdone", 32'(S_AXI_BVALID), 32'd0);
    $display("WR addr=18 data=1234abcd split AW/W");
    axi_read(6'h18, rd, rr);
    chk("t5_cmp", rd, 32'h1234_ABCD);

    // 6: out-of-range channel and partial strobe
    axi_read(6'h38, rd, rr);
    chk("t6_oor_rd", rd, 32'h0);
    chk("t6_oor_rresp", 32'(rr), 32'd0);
    axi_write(6'h38, 32'hDEAD_BEEF, 4'hF);
    axi_write(6'h30, 32'hF, 4'hF);
    axi_read(6'h08, rd, rr);
    chk("t6_ch0_cmp", rd, 32'd5);
    axi_read(6'h00, rd, rr);
    chk("t6_ch0_ctrl", rd, 32'h0);
    axi_read(6'h38, rd, rr);
    chk("t6_oor_rd2", rd, 32'h0);
    axi_write(6'h28, 32'hAABB_CCDD, 4'hF);
    axi_write(6'h28, 32'h1122_3344, 4'h1);
    axi_read(6'h28, rd, rr);
    chk("t6_strb", rd, 32'hAABB_CC44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
